// File: rtl/cs_pkg.sv
// Shared constants and types for the CS Y-result path.
package cs_pkg;

   localparam int unsigned CS_DATA_W = 10;
   localparam int unsigned CS_WIN    = 9;
   localparam int unsigned CS_WARMUP = CS_WIN - 1;

   typedef enum logic {
      WARM_UP = 1'b0,
      RUN     = 1'b1
   } cs_state_e;

endpackage

// File: rtl/cs_y_buffer_if.sv
// Stream-in / handshake-out bundle between the CS block, the Y buffer and its consumer.
interface cs_y_buffer_if
   import cs_pkg::*;
#(
   parameter int unsigned DATA_W = CS_DATA_W,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned DROP_W = 16
) ();

   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] y_in;
   logic              y_in_en;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic [LVL_W-1:0]  level;
   logic              warm;
   logic              overflow;
   logic [DROP_W-1:0] drop_cnt;

   modport master (
      output y_in, y_in_en, out_ready,
      input  out_data, out_valid, level, warm, overflow, drop_cnt
   );

   modport slave (
      input  y_in, y_in_en, out_ready,
      output out_data, out_valid, level, warm, overflow, drop_cnt
   );

endinterface

// File: rtl/cs_sync_fifo.sv
// Show-ahead synchronous FIFO; head word and valid are registered so they
// reset cleanly even though the storage array does not.
module cs_sync_fifo #(
   parameter int unsigned DATA_W = 10,
   parameter int unsigned DEPTH  = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wr_en,
   input  logic [DATA_W-1:0]            wr_data,
   input  logic                         rd_en,
   output logic [DATA_W-1:0]            rd_data,
   output logic                         rd_valid,
   output logic [$clog2(DEPTH):0]       level,
   output logic                         full_c
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              rd_ok, wr_ok;

   assign full_c   = (level_q == LVL_W'(DEPTH));
   assign rd_data  = data_q;
   assign rd_valid = valid_q;
   assign level    = level_q;

   // Next head word: a write landing in the slot the read pointer is about
   // to point at must be forwarded, since mem_q only updates at the edge.
   always_comb begin
      rd_ok    = rd_en && valid_q;
      wr_ok    = wr_en && (!full_c || rd_ok);
      rd_ptr_d = rd_ptr_q + PTR_W'(rd_ok);
      wr_ptr_d = wr_ptr_q + PTR_W'(wr_ok);
      level_d  = level_q;
      if (wr_ok && !rd_ok) begin
         level_d = level_q + LVL_W'(1);
      end else if (rd_ok && !wr_ok) begin
         level_d = level_q - LVL_W'(1);
      end
      valid_d = (level_d != '0);
      data_d  = data_q;
      if (valid_d) begin
         if (wr_ok && (wr_ptr_q == rd_ptr_d)) begin
            data_d = wr_data;
         end else begin
            data_d = mem_q[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
      end
   end

   // Storage carries no reset; only entries below level are ever observed.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: rtl/cs_y_buffer.sv
// Y-result buffer behind the CS block: drops the window-fill warm-up results,
// then queues valid results and counts any that arrive while the FIFO is full.
module cs_y_buffer
   import cs_pkg::*;
#(
   parameter int unsigned DATA_W = CS_DATA_W,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned WARMUP = CS_WARMUP,
   parameter int unsigned DROP_W = 16
) (
   input  logic           clk,
   input  logic           reset,
   cs_y_buffer_if.slave   bus
);

   localparam int unsigned WCNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
   localparam cs_state_e   RST_STATE = (WARMUP == 0) ? RUN : WARM_UP;

   cs_state_e         state_q, state_d;
   logic [WCNT_W-1:0] warm_cnt_q, warm_cnt_d;
   logic              warm_q, warm_d;
   logic              overflow_q, overflow_d;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

   logic              fifo_full_c;
   logic              fifo_valid;
   logic              rd_fire;
   logic              wr_en;
   logic              drop;

   // Warm-up counting, write gating and drop accounting.
   always_comb begin
      state_d    = state_q;
      warm_cnt_d = warm_cnt_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      rd_fire    = fifo_valid && bus.out_ready;
      wr_en      = 1'b0;
      drop       = 1'b0;

      case (state_q)
         WARM_UP: begin
            if (bus.y_in_en) begin
               warm_cnt_d = warm_cnt_q + WCNT_W'(1);
               if (warm_cnt_q == WCNT_W'(WARMUP - 1)) begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (bus.y_in_en) begin
               if (!fifo_full_c || rd_fire) begin
                  wr_en = 1'b1;
               end else begin
                  drop = 1'b1;
               end
            end
         end
         default: state_d = RST_STATE;
      endcase

      if (drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + DROP_W'(1);
         end
      end
      warm_d = (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RST_STATE;
         warm_cnt_q <= '0;
         warm_q     <= (RST_STATE == RUN);
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         warm_cnt_q <= warm_cnt_d;
         warm_q     <= warm_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   cs_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_data  (bus.y_in),
      .rd_en    (bus.out_ready),
      .rd_data  (bus.out_data),
      .rd_valid (fifo_valid),
      .level    (bus.level),
      .full_c   (fifo_full_c)
   );

   assign bus.out_valid = fifo_valid;
   assign bus.warm      = warm_q;
   assign bus.overflow  = overflow_q;
   assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_cs_y_buffer.sv
// Scoreboard bench for cs_y_buffer: expected words are queued at stimulus time
// and popped by a monitor whenever the consumer handshake completes.
module tb_cs_y_buffer;

   localparam int unsigned DATA_W = 10;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned WARMUP = 8;
   localparam int unsigned DROP_W = 16;

   logic clk;
   logic reset;

   cs_y_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

   cs_y_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .WARMUP (WARMUP),
      .DROP_W (DROP_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock with the given strobe; returns 1 time unit after the edge.
   task automatic cyc(input bit en, input logic [DATA_W-1:0] d);
      bus.y_in_en = en;
      bus.y_in    = en ? d : 'x;
      @(posedge clk);
      #1;
   endtask

   // Monitor: every completed handshake must match the next expected word.
   always @(negedge clk) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_word: got 0x%0h, expected no word (t=%0t)", bus.out_data, $time);
         end else begin
            int e;
            e = exp_q.pop_front();
            if (int'(bus.out_data) != e) begin
               n_fail++;
               $display("FAIL out_data: got 0x%0h, expected 0x%0h (t=%0t)", bus.out_data, e, $time);
            end
         end
      end
   end

   initial begin
      reset         = 1'b1;
      bus.y_in      = '0;
      bus.y_in_en   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_level",     int'(bus.level),     0);
      chk("rst_warm",      int'(bus.warm),      0);
      chk("rst_overflow",  int'(bus.overflow),  0);
      chk("rst_drop_cnt",  int'(bus.drop_cnt),  0);
      chk("rst_out_data",  int'(bus.out_data),  0);
      reset = 1'b0;

      // Warm-up discard: 0x100..0x107 dropped, 0x108 first valid.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (i >= 8) exp_q.push_back(32'h100 + i);
         cyc(1'b1, DATA_W'(32'h100 + i));
         if (i == 6) chk("warm_before_8th", int'(bus.warm), 0);
         if (i == 7) begin
            chk("warm_after_8th",  int'(bus.warm),      1);
            chk("no_valid_warmup", int'(bus.out_valid), 0);
         end
         if (i == 8) begin
            chk("first_valid",     int'(bus.out_valid), 1);
            chk("first_data",      int'(bus.out_data),  32'h108);
         end
      end
      repeat (3) cyc(1'b0, '0);
      chk("warmup_drain_level", int'(bus.level),     0);
      chk("warmup_drain_valid", int'(bus.out_valid), 0);

      // Backpressure fill: 16 stored, 4 dropped.
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         if (i <= 16) exp_q.push_back(i);
         cyc(1'b1, DATA_W'(i));
      end
      cyc(1'b0, '0);
      chk("full_level",    int'(bus.level),     16);
      chk("full_overflow", int'(bus.overflow),  1);
      chk("full_drop_cnt", int'(bus.drop_cnt),  4);
      chk("full_head",     int'(bus.out_data),  1);
      chk("full_stable",   int'(bus.out_valid), 1);

      // Read and write together while full: no drop, level holds.
      bus.out_ready = 1'b1;
      exp_q.push_back(32'h3FF);
      cyc(1'b1, DATA_W'(32'h3FF));
      chk("rw_full_level",    int'(bus.level),    16);
      chk("rw_full_overflow", int'(bus.overflow), 1);
      chk("rw_full_drop_cnt", int'(bus.drop_cnt), 4);
      repeat (18) cyc(1'b0, '0);
      chk("drain_level",   int'(bus.level),     0);
      chk("drain_valid",   int'(bus.out_valid), 0);
      chk("drain_sb_left", exp_q.size(),        0);

      // Empty with ready asserted: nothing moves; one write shows a cycle later.
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, '0);
         chk("empty_valid", int'(bus.out_valid), 0);
         chk("empty_level", int'(bus.level),     0);
      end
      exp_q.push_back(32'h2AA);
      bus.y_in_en = 1'b1;
      bus.y_in    = DATA_W'(32'h2AA);
      chk("no_bypass", int'(bus.out_valid), 0);
      @(posedge clk);
      #1;
      bus.y_in_en = 1'b0;
      bus.y_in    = 'x;
      chk("single_valid", int'(bus.out_valid), 1);
      chk("single_level", int'(bus.level),     1);
      cyc(1'b0, '0);
      chk("single_gone_valid", int'(bus.out_valid), 0);
      chk("single_gone_level", int'(bus.level),     0);

      // Reset mid-run with 5 stored and overflow still set.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) cyc(1'b1, DATA_W'(32'h050 + i));
      chk("pre_rst_level",    int'(bus.level),    5);
      chk("pre_rst_overflow", int'(bus.overflow), 1);
      reset = 1'b1;
      cyc(1'b0, '0);
      reset = 1'b0;
      chk("mid_rst_level",    int'(bus.level),     0);
      chk("mid_rst_valid",    int'(bus.out_valid), 0);
      chk("mid_rst_overflow", int'(bus.overflow),  0);
      chk("mid_rst_drop_cnt", int'(bus.drop_cnt),  0);
      chk("mid_rst_warm",     int'(bus.warm),      0);

      // Gapped strobes: exactly 8 strobes discarded whatever the gap lengths.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i >= 8) exp_q.push_back(32'h200 + i);
         cyc(1'b1, DATA_W'(32'h200 + i));
         if (i == 6) chk("gap_warm_before", int'(bus.warm), 0);
         if (i == 7) begin
            chk("gap_warm_after",   int'(bus.warm),  1);
            chk("gap_discard_lvl",  int'(bus.level), 0);
         end
         repeat ((i % 3) + 1) cyc(1'b0, '0);
      end
      repeat (4) cyc(1'b0, '0);
      chk("gap_end_level",   int'(bus.level), 0);
      chk("gap_end_sb_left", exp_q.size(),    0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
